raw_to_rgb_demosaic: RTL and testbench

//  Bayer RAW to RGB demosaic: the video stage directly downstream of rgb_to_raw.

---
 rtl/raw_to_rgb_demosaic_pkg.sv | 15 +
 rtl/raw_to_rgb_demosaic_if.sv | 29 ++
 rtl/raw_to_rgb_demosaic_line_buf.sv | 27 ++
 rtl/raw_to_rgb_demosaic.sv | 178 +++++++++++++++++
 tb/tb_raw_to_rgb_demosaic.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/raw_to_rgb_demosaic_pkg.sv
// Shared video definitions: Bayer mode codes and RAW-to-component bit reduction.
// Pure constants and a function; no timing or flow-control behaviour.
package video_pkg;

    localparam logic BAYER_RGGB = 1'b0;
    localparam logic BAYER_BGGR = 1'b1;

    // Keeps the top bpp bits of a raw_bits-wide sample (truncation, no rounding).
    function automatic logic [31:0] raw_msb(input logic [31:0] raw, input int raw_bits, input int bpp);
        logic [31:0] mask;
        mask = (32'd1 << bpp) - 32'd1;
        return (raw >> (raw_bits - bpp)) & mask;
    endfunction

endpackage

// File: rtl/raw_to_rgb_demosaic_if.sv
// Video bus between the RAW source and the RGB sink: sync flags plus C_PORT_NUM lanes each way.
// Wires only; no latency and no backpressure (video timing is source-driven).
interface raw_to_rgb_demosaic_if #(
    parameter int C_BPP         = 8,
    parameter int C_PORT_NUM    = 4,
    parameter int C_RAW_BIT_NUM = 12
);
    logic                              S_VS;
    logic                              S_HS;
    logic                              S_DE;
    logic [C_RAW_BIT_NUM*C_PORT_NUM-1:0] S_RAW;
    logic                              M_VS;
    logic                              M_HS;
    logic                              M_DE;
    logic [C_BPP*C_PORT_NUM-1:0]       M_R;
    logic [C_BPP*C_PORT_NUM-1:0]       M_G;
    logic [C_BPP*C_PORT_NUM-1:0]       M_B;

    modport slave (
        input  S_VS, S_HS, S_DE, S_RAW,
        output M_VS, M_HS, M_DE, M_R, M_G, M_B
    );

    modport master (
        output S_VS, S_HS, S_DE, S_RAW,
        input  M_VS, M_HS, M_DE, M_R, M_G, M_B
    );

endinterface

// File: rtl/raw_to_rgb_demosaic_line_buf.sv
// Single-clock read-first line buffer holding the previous RAW line, one word per clock.
// Read data valid 1 clock after the address; no backpressure; contents never cleared.
module raw_line_buf #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 48,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdat,
    output logic [WIDTH-1:0] rdat
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdat_q;

    always_ff @(posedge clk) begin
        rdat_q <= mem[addr];
        if (we) begin
            mem[addr] <= wdat;
        end
    end

    assign rdat = rdat_q;

endmodule

// File: rtl/raw_to_rgb_demosaic.sv
// Bayer RAW to RGB demosaic over 2x2 windows of column pairs (previous line + current line).
// Fixed 2-clock latency for syncs and data; no backpressure.
module raw_to_rgb_demosaic
    import video_pkg::*;
#(
    parameter int C_BPP         = 8,
    parameter int C_PORT_NUM    = 4,
    parameter int C_RAW_BIT_NUM = 12,
    parameter     C_RAW_MODE    = "RGGB",
    parameter int C_MAX_WIDTH   = 4096
) (
    input  logic                  VID_CLK,
    input  logic                  VID_RST,
    raw_to_rgb_demosaic_if.slave  vid
);

    localparam int   DEPTH   = C_MAX_WIDTH / C_PORT_NUM;
    localparam int   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int   CW      = $clog2(DEPTH + 1);
    localparam int   RW      = C_RAW_BIT_NUM * C_PORT_NUM;
    localparam int   OW      = C_BPP * C_PORT_NUM;
    localparam int   NPAIR   = C_PORT_NUM / 2;
    localparam logic MODE    = (C_RAW_MODE == "BGGR") ? BAYER_BGGR : BAYER_RGGB;
    localparam bit   SWAP_RB = (MODE == BAYER_BGGR);

    logic          row_odd_q, row_odd_d;
    logic          first_line_q, first_line_d;
    logic [CW-1:0] wr_addr_q, wr_addr_d;

    logic          s1_vs_q, s1_vs_d, s1_hs_q, s1_hs_d, s1_de_q, s1_de_d;
    logic          s1_row_odd_q, s1_row_odd_d, s1_first_q, s1_first_d, s1_ovf_q, s1_ovf_d;
    logic [RW-1:0] s1_raw_q, s1_raw_d;

    logic          m_vs_q, m_vs_d, m_hs_q, m_hs_d, m_de_q, m_de_d;
    logic [OW-1:0] m_r_q, m_r_d, m_g_q, m_g_d, m_b_q, m_b_d;

    logic [RW-1:0] prev_rd;
    logic [OW-1:0] pix_r, pix_g, pix_b;
    logic          vs_pos, de_neg, in_range, buf_we;

    // Stage-1 sync registers double as the previous-cycle samples for edge detection.
    assign vs_pos   = vid.S_VS & ~s1_vs_q;
    assign de_neg   = ~vid.S_DE & s1_de_q;
    assign in_range = (wr_addr_q < CW'(DEPTH));
    assign buf_we   = vid.S_DE & in_range;

    raw_line_buf #(
        .DEPTH (DEPTH),
        .WIDTH (RW),
        .AW    (AW)
    ) u_line_buf (
        .clk  (VID_CLK),
        .we   (buf_we),
        .addr (wr_addr_q[AW-1:0]),
        .wdat (vid.S_RAW),
        .rdat (prev_rd)
    );

    always_comb begin
        row_odd_d    = row_odd_q;
        first_line_d = first_line_q;
        wr_addr_d    = wr_addr_q;
        if (vs_pos) begin
            row_odd_d    = 1'b0;
            first_line_d = 1'b1;
            wr_addr_d    = '0;
        end else if (de_neg) begin
            row_odd_d    = ~row_odd_q;
            first_line_d = 1'b0;
            wr_addr_d    = '0;
        end else if (buf_we) begin
            wr_addr_d    = wr_addr_q + CW'(1);
        end

        s1_vs_d      = vid.S_VS;
        s1_hs_d      = vid.S_HS;
        s1_de_d      = vid.S_DE;
        s1_raw_d     = vid.S_RAW;
        s1_row_odd_d = row_odd_q;
        s1_first_d   = first_line_q;
        s1_ovf_d     = ~in_range;

        m_vs_d = s1_vs_q;
        m_hs_d = s1_hs_q;
        m_de_d = s1_de_q;
        m_r_d  = s1_de_q ? pix_r : '0;
        m_g_d  = s1_de_q ? pix_g : '0;
        m_b_d  = s1_de_q ? pix_b : '0;
    end

    always_ff @(posedge VID_CLK or posedge VID_RST) begin
        if (VID_RST) begin
            row_odd_q    <= 1'b0;
            first_line_q <= 1'b1;
            wr_addr_q    <= '0;
            s1_vs_q      <= 1'b0;
            s1_hs_q      <= 1'b0;
            s1_de_q      <= 1'b0;
            s1_raw_q     <= '0;
            s1_row_odd_q <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_ovf_q     <= 1'b0;
            m_vs_q       <= 1'b0;
            m_hs_q       <= 1'b0;
            m_de_q       <= 1'b0;
            m_r_q        <= '0;
            m_g_q        <= '0;
            m_b_q        <= '0;
        end else begin
            row_odd_q    <= row_odd_d;
            first_line_q <= first_line_d;
            wr_addr_q    <= wr_addr_d;
            s1_vs_q      <= s1_vs_d;
            s1_hs_q      <= s1_hs_d;
            s1_de_q      <= s1_de_d;
            s1_raw_q     <= s1_raw_d;
            s1_row_odd_q <= s1_row_odd_d;
            s1_first_q   <= s1_first_d;
            s1_ovf_q     <= s1_ovf_d;
            m_vs_q       <= m_vs_d;
            m_hs_q       <= m_hs_d;
            m_de_q       <= m_de_d;
            m_r_q        <= m_r_d;
            m_g_q        <= m_g_d;
            m_b_q        <= m_b_d;
        end
    end

    for (genvar k = 0; k < NPAIR; k++) begin : g_pair
        logic [C_RAW_BIT_NUM-1:0] c0, c1, p0, p1;
        logic [C_RAW_BIT_NUM-1:0] cur_col, prev_col, g_cur, g_prev, r_raw, b_raw;
        logic [C_RAW_BIT_NUM:0]   g_sum;
        logic                     use_cur;

        assign c0      = s1_raw_q[(2*k)*C_RAW_BIT_NUM +: C_RAW_BIT_NUM];
        assign c1      = s1_raw_q[(2*k+1)*C_RAW_BIT_NUM +: C_RAW_BIT_NUM];
        assign p0      = prev_rd[(2*k)*C_RAW_BIT_NUM +: C_RAW_BIT_NUM];
        assign p1      = prev_rd[(2*k+1)*C_RAW_BIT_NUM +: C_RAW_BIT_NUM];
        assign use_cur = s1_first_q | s1_ovf_q;

        // cur_col/prev_col are the non-green samples of the current and previous row.
        always_comb begin
            if (s1_row_odd_q) begin
                cur_col  = c1;
                g_cur    = c0;
                prev_col = p0;
                g_prev   = p1;
            end else begin
                cur_col  = c0;
                g_cur    = c1;
                prev_col = p1;
                g_prev   = p0;
            end
            if (use_cur) begin
                prev_col = '0;
                g_prev   = g_cur;
            end
        end

        assign r_raw = (s1_row_odd_q ^ SWAP_RB) ? prev_col : cur_col;
        assign b_raw = (s1_row_odd_q ^ SWAP_RB) ? cur_col : prev_col;
        assign g_sum = {1'b0, g_cur} + {1'b0, g_prev} + (C_RAW_BIT_NUM+1)'(1);

        for (genvar j = 0; j < 2; j++) begin : g_lane
            assign pix_r[(2*k+j)*C_BPP +: C_BPP] = C_BPP'(raw_msb(32'(r_raw), C_RAW_BIT_NUM, C_BPP));
            assign pix_g[(2*k+j)*C_BPP +: C_BPP] = C_BPP'(raw_msb(32'(g_sum >> 1), C_RAW_BIT_NUM, C_BPP));
            assign pix_b[(2*k+j)*C_BPP +: C_BPP] = C_BPP'(raw_msb(32'(b_raw), C_RAW_BIT_NUM, C_BPP));
        end
    end

    assign vid.M_VS = m_vs_q;
    assign vid.M_HS = m_hs_q;
    assign vid.M_DE = m_de_q;
    assign vid.M_R  = m_r_q;
    assign vid.M_G  = m_g_q;
    assign vid.M_B  = m_b_q;

endmodule

// File: tb/tb_raw_to_rgb_demosaic.sv
// Bench for raw_to_rgb_demosaic: per-cycle comparison against a Bayer-colour reference model.
module tb_raw_to_rgb_demosaic;

    localparam int RB   = 12;
    localparam int BPP  = 8;
    localparam int P    = 4;
    localparam int MAXW = 16;
    localparam     C_MODE  = "RGGB";
    localparam bit TB_SWAP = (C_MODE == "BGGR");

    typedef struct packed {
        logic        vs, hs, de;
        logic [31:0] r, g, b;
    } exp_t;

    logic VID_CLK = 1'b0;
    logic VID_RST = 1'b1;
    always #5 VID_CLK = ~VID_CLK;

    raw_to_rgb_demosaic_if #(.C_BPP(BPP), .C_PORT_NUM(P), .C_RAW_BIT_NUM(RB)) vid();

    raw_to_rgb_demosaic #(
        .C_BPP(BPP), .C_PORT_NUM(P), .C_RAW_BIT_NUM(RB), .C_RAW_MODE(C_MODE), .C_MAX_WIDTH(MAXW)
    ) dut (
        .VID_CLK (VID_CLK),
        .VID_RST (VID_RST),
        .vid     (vid)
    );

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_arr [int];
    exp_t last_exp;
    exp_t line_exp [8];
    exp_t cmp_e;

    // Reference model state: row parity, first-line flag, pixel column, stored previous row.
    bit   m_odd, m_first, m_prev_vs, m_prev_de;
    int   m_col;
    int   prev_line [MAXW];

    localparam logic [47:0] EVEN_W = {12'h500, 12'hA00, 12'h500, 12'hA00};
    localparam logic [47:0] ODD_W  = {12'h300, 12'h700, 12'h300, 12'h700};

    always @(posedge VID_CLK) cyc <= cyc + 1;

    always @(negedge VID_CLK) begin
        if (exp_arr.exists(cyc)) begin
            cmp_e = exp_arr[cyc];
            exp_arr.delete(cyc);
            n_tests++;
            if (vid.M_VS !== cmp_e.vs || vid.M_HS !== cmp_e.hs || vid.M_DE !== cmp_e.de ||
                vid.M_R !== cmp_e.r || vid.M_G !== cmp_e.g || vid.M_B !== cmp_e.b) begin
                n_fail++;
                $display("FAIL out_cyc%0d got vs%b hs%b de%b r=%h g=%h b=%h want vs%b hs%b de%b r=%h g=%h b=%h",
                         cyc, vid.M_VS, vid.M_HS, vid.M_DE, vid.M_R, vid.M_G, vid.M_B,
                         cmp_e.vs, cmp_e.hs, cmp_e.de, cmp_e.r, cmp_e.g, cmp_e.b);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    // 0 = red, 1 = green, 2 = blue for a sample at (row parity, column).
    function automatic int colour_of(input bit odd_row, input int col);
        if (!odd_row && (col % 2 == 0)) return TB_SWAP ? 2 : 0;
        if (odd_row && (col % 2 == 1))  return TB_SWAP ? 0 : 2;
        return 1;
    endfunction

    task automatic model_reset();
        m_odd = 1'b0; m_first = 1'b1; m_col = 0; m_prev_vs = 1'b0; m_prev_de = 1'b0;
    endtask

    task automatic model_step(input logic vs, input logic hs, input logic de, input logic [47:0] raw);
        exp_t e;
        e = '{vs: vs, hs: hs, de: de, r: 32'h0, g: 32'h0, b: 32'h0};
        if (de) begin
            for (int k = 0; k < P/2; k++) begin
                int col, rv, bv, gs, gn, gv, px, c;
                col = m_col + 2*k; rv = 0; bv = 0; gs = 0; gn = 0;
                for (int j = 0; j < 2; j++) begin
                    for (int rowsel = 0; rowsel < 2; rowsel++) begin
                        if (rowsel == 0 || (!m_first && col < MAXW)) begin
                            px = (rowsel == 0) ? int'(raw[(2*k+j)*RB +: RB]) : prev_line[col+j];
                            c  = colour_of((rowsel == 0) ? m_odd : !m_odd, col + j);
                            if (c == 0) rv = px;
                            else if (c == 2) bv = px;
                            else begin gs += px; gn++; end
                        end
                    end
                end
                gv = (gn == 2) ? (gs + 1) / 2 : gs;
                for (int j = 0; j < 2; j++) begin
                    e.r[(2*k+j)*BPP +: BPP] = 8'(rv >> (RB - BPP));
                    e.g[(2*k+j)*BPP +: BPP] = 8'(gv >> (RB - BPP));
                    e.b[(2*k+j)*BPP +: BPP] = 8'(bv >> (RB - BPP));
                end
            end
            for (int j = 0; j < P; j++)
                if (m_col + j < MAXW) prev_line[m_col + j] = int'(raw[j*RB +: RB]);
            m_col += P;
        end
        if (vs && !m_prev_vs) begin
            m_odd = 1'b0; m_first = 1'b1; m_col = 0;
        end else if (!de && m_prev_de) begin
            m_odd = !m_odd; m_first = 1'b0; m_col = 0;
        end
        m_prev_vs = vs; m_prev_de = de;
        exp_arr[cyc + 2] = e;
        last_exp = e;
    endtask

    task automatic drive(input logic vs, input logic hs, input logic de, input logic [47:0] raw);
        @(posedge VID_CLK);
        #1;
        VID_RST = 1'b0;
        vid.S_VS = vs; vid.S_HS = hs; vid.S_DE = de; vid.S_RAW = raw;
        model_step(vs, hs, de, raw);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 48'h0);
    endtask

    task automatic frame_start();
        drive(1'b1, 1'b0, 1'b0, 48'h0);
        drive(1'b1, 1'b0, 1'b0, 48'h0);
        idle(2);
    endtask

    task automatic send_line(input int nw, input logic [47:0] w, input logic [47:0] wl, input bit rnd);
        logic [63:0] t;
        for (int i = 0; i < nw; i++) begin
            t = {$urandom(), $urandom()};
            drive(1'b0, 1'b0, 1'b1, rnd ? t[47:0] : ((i == nw - 1) ? wl : w));
            if (i < 8) line_exp[i] = last_exp;
        end
        idle(1);
        drive(1'b0, 1'b1, 1'b0, 48'h0);
        idle(1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge VID_CLK);
            #1;
            VID_RST = 1'b1;
            vid.S_VS = 1'b0; vid.S_HS = 1'b0; vid.S_DE = 1'b0; vid.S_RAW = '0;
            model_reset();
            for (int c = cyc; c <= cyc + 2; c++) exp_arr[c] = '0;
            #1;
            chk("rst_rgb", vid.M_R | vid.M_G | vid.M_B, 32'h0);
            chk("rst_sync", {29'h0, vid.M_VS, vid.M_HS, vid.M_DE}, 32'h0);
        end
    endtask

    initial begin
        vid.S_VS = 1'b0; vid.S_HS = 1'b0; vid.S_DE = 1'b0; vid.S_RAW = '0;
        for (int i = 0; i < MAXW; i++) prev_line[i] = 0;
        model_reset();
        do_reset(3);

        // Fill every buffer word once so no later line can see uninitialised RAM.
        frame_start();
        send_line(MAXW / P, 48'h0, 48'h0, 1'b1);

        // 4-line frame with flat colour planes.
        frame_start();
        send_line(2, EVEN_W, EVEN_W, 1'b0);
        chk("l0_r", line_exp[1].r, 32'hA0A0A0A0);
        chk("l0_g", line_exp[1].g, 32'h50505050);
        chk("l0_b", line_exp[1].b, 32'h00000000);
        send_line(2, ODD_W, ODD_W, 1'b0);
        chk("l1_r", line_exp[1].r, 32'hA0A0A0A0);
        chk("l1_g", line_exp[1].g, 32'h60606060);
        chk("l1_b", line_exp[1].b, 32'h30303030);
        send_line(2, EVEN_W, EVEN_W, 1'b0);
        chk("l2_g", line_exp[0].g, 32'h60606060);
        chk("l2_b", line_exp[0].b, 32'h30303030);
        send_line(2, ODD_W, ODD_W, 1'b0);
        chk("l3_r", line_exp[0].r, 32'hA0A0A0A0);

        // Half-up rounding of the green average.
        frame_start();
        send_line(2, {12'h0F0, 12'h000, 12'h0F0, 12'h000}, {12'h0F0, 12'h000, 12'h0F0, 12'h000}, 1'b0);
        send_line(2, {12'h000, 12'h100, 12'h000, 12'h100}, {12'h000, 12'h100, 12'h000, 12'h100}, 1'b0);
        chk("round_g", line_exp[0].g, 32'h0F0F0F0F);

        // New frame after line 1 restarts on an even first line.
        frame_start();
        send_line(2, EVEN_W, EVEN_W, 1'b0);
        send_line(2, ODD_W, ODD_W, 1'b0);
        frame_start();
        send_line(2, EVEN_W, EVEN_W, 1'b0);
        chk("vs_b", line_exp[0].b, 32'h00000000);
        chk("vs_g", line_exp[0].g, 32'h50505050);

        // Reset in the middle of a line; the following line is a first line.
        frame_start();
        send_line(2, EVEN_W, EVEN_W, 1'b0);
        send_line(2, ODD_W, ODD_W, 1'b0);
        drive(1'b0, 1'b0, 1'b1, EVEN_W);
        drive(1'b0, 1'b0, 1'b1, EVEN_W);
        do_reset(3);
        idle(2);
        send_line(2, EVEN_W, EVEN_W, 1'b0);
        chk("postrst_b", line_exp[0].b, 32'h00000000);
        chk("postrst_r", line_exp[0].r, 32'hA0A0A0A0);

        // Lines longer than the buffer: overflow words fall back to the current row.
        frame_start();
        send_line(5, EVEN_W, EVEN_W, 1'b0);
        send_line(5, ODD_W, 48'h0, 1'b0);
        send_line(5, EVEN_W, EVEN_W, 1'b0);
        chk("ovf_w0_b", line_exp[0].b, 32'h30303030);
        chk("ovf_w4_b", line_exp[4].b, 32'h00000000);
        chk("ovf_w4_g", line_exp[4].g, 32'h50505050);

        // Random frames: random data, line lengths, blanking and line counts.
        for (int f = 0; f < 12; f++) begin
            int nl;
            frame_start();
            nl = int'($urandom_range(2, 5));
            for (int l = 0; l < nl; l++) begin
                send_line(int'($urandom_range(1, 6)), 48'h0, 48'h0, 1'b1);
                idle(int'($urandom_range(0, 3)));
            end
        end

        idle(2);
        repeat (3) @(posedge VID_CLK);
        @(negedge VID_CLK);
        #1;
        chk("drain", exp_arr.num(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
